heartbeat_monitor: RTL and testbench

HEARTBEAT_MONITOR -- requirements
Module: heartbeat_monitor

---
 rtl/heartbeat_monitor_if.sv | 24 ++
 rtl/heartbeat_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_heartbeat_monitor.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor bus: heartbeat input, fault clear, status outputs.
// Ports: master drives hb_in/clr_fault; slave (monitor) drives status.
interface heartbeat_monitor_if;
    logic        hb_in;
    logic        clr_fault;
    logic        locked;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] period_meas;
    logic [15:0] err_cnt;
    logic        rst_req;

    modport master (
        output hb_in, clr_fault,
        input  locked, fault, fault_code,
        input  period_meas, err_cnt, rst_req
    );

    modport slave (
        input  hb_in, clr_fault,
        output locked, fault, fault_code,
        output period_meas, err_cnt, rst_req
    );
endinterface

// File: rtl/heartbeat_monitor.sv
// Heartbeat period monitor: sync hb_in, measure edge spacing, lock/fault FSM.
// Ports: clk, rst_n (async low), bus (slave: hb_in, clr_fault -> status).
// Optional: HBMON_RST_REQ_EN builds the rst_req pulse generator.
module heartbeat_monitor #(
    parameter int NOM_PERIOD    = 50000000,
    parameter int TOL           = 500000,
    parameter int LOCK_CNT      = 4,
    parameter int RST_PULSE_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    heartbeat_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_INIT,
        S_ACQ,
        S_LOCK,
        S_FAULT
    } state_t;

    localparam logic [31:0] LO  = 32'(NOM_PERIOD - TOL);
    localparam logic [31:0] HI  = 32'(NOM_PERIOD + TOL);
    localparam logic [31:0] TMO = HI + 32'd1;
    localparam int          GW  = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_CNT);

    logic          sync1_q, sync2_q, sync3_q;
    logic          edge_pulse;
    logic [31:0]   cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          locked_q, locked_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
    logic [31:0]   pm_q, pm_d;
    logic [15:0]   err_q, err_d;
    logic          fault_enter;
    logic          early, in_win, timeout;

    // Either transition of the synchronized level is a heartbeat tick.
    assign edge_pulse = sync2_q ^ sync3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.hb_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // cnt_q equals the period P in the cycle an edge_pulse arrives.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_pulse) begin
            cnt_d = 32'd1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign early   = cnt_q < LO;
    assign in_win  = !early && (cnt_q <= HI);
    assign timeout = !edge_pulse && (cnt_q >= TMO);

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        code_d      = code_q;
        pm_d        = pm_q;
        err_d       = err_q;
        fault_enter = 1'b0;

        unique case (state_q)
            S_INIT: begin
                if (edge_pulse) begin
                    state_d = S_ACQ;
                    good_d  = '0;
                end
            end
            S_ACQ: begin
                if (edge_pulse) begin
                    pm_d = cnt_q;
                    if (early) begin
                        good_d = '0;
                    end else if (!in_win) begin
                        state_d = S_INIT;
                        good_d  = '0;
                    end else if (good_q + GW'(1) == LOCK_N) begin
                        state_d = S_LOCK;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end else if (timeout) begin
                    state_d = S_INIT;
                    good_d  = '0;
                end
            end
            S_LOCK: begin
                if (edge_pulse) begin
                    pm_d = cnt_q;
                    if (early) begin
                        state_d     = S_FAULT;
                        code_d      = 2'b01;
                        fault_enter = 1'b1;
                    end else if (!in_win) begin
                        state_d     = S_FAULT;
                        code_d      = 2'b10;
                        fault_enter = 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = S_FAULT;
                    code_d      = 2'b10;
                    fault_enter = 1'b1;
                end
            end
            S_FAULT: begin
                if (bus.clr_fault) begin
                    state_d = S_INIT;
                    code_d  = 2'b00;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                good_d  = '0;
            end
        endcase

        if (fault_enter && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end

        locked_d = (state_d == S_LOCK);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
            pm_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            pm_q     <= pm_d;
            err_q    <= err_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.period_meas = pm_q;
    assign bus.err_cnt     = err_q;

`ifdef HBMON_RST_REQ_EN
    localparam int RW = $clog2(RST_PULSE_LEN + 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rreq_q, rreq_d;

    // Pulse rises with fault; rcnt_q holds the cycles still to go.
    always_comb begin
        rcnt_d = rcnt_q;
        rreq_d = 1'b0;
        if (fault_enter) begin
            rcnt_d = RW'(RST_PULSE_LEN - 1);
            rreq_d = 1'b1;
        end else if (rcnt_q != '0) begin
            rcnt_d = rcnt_q - RW'(1);
            rreq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            rreq_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rreq_q <= rreq_d;
        end
    end

    assign bus.rst_req = rreq_q;
`else
    assign bus.rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor (NOM=100, TOL=5, LOCK_CNT=2).
// Prints one "passed/total" summary line at the end.
module tb_heartbeat_monitor;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   since;

    heartbeat_monitor_if bus ();

    heartbeat_monitor #(
        .NOM_PERIOD    (100),
        .TOL           (5),
        .LOCK_CNT      (2),
        .RST_PULSE_LEN (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
        since += k;
    endtask

    // Toggle hb_in 'gap' cycles after the previous toggle.
    task automatic toggle(input int gap);
        if (gap > since) wait_cyc(gap - since);
        bus.hb_in = ~bus.hb_in;
        since = 0;
    endtask

    task automatic pulse_clr();
        bus.clr_fault = 1'b1;
        wait_cyc(1);
        bus.clr_fault = 1'b0;
        wait_cyc(1);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.hb_in     = 1'b0;
        bus.clr_fault = 1'b0;
        since         = 0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.locked !== 1'b0)
            $display("FAIL rst_locked got %0b want 0", bus.locked);
        else n_pass++;
        n_chk++;
        if (bus.fault !== 1'b0)
            $display("FAIL rst_fault got %0b want 0", bus.fault);
        else n_pass++;
        n_chk++;
        if (bus.fault_code !== 2'b00)
            $display("FAIL rst_code got %0b want 00", bus.fault_code);
        else n_pass++;
        n_chk++;
        if (bus.period_meas !== 32'd0)
            $display("FAIL rst_pm got %0d want 0", bus.period_meas);
        else n_pass++;
        n_chk++;
        if (bus.err_cnt !== 16'd0)
            $display("FAIL rst_err got %0d want 0", bus.err_cnt);
        else n_pass++;
        n_chk++;
        if (bus.rst_req !== 1'b0)
            $display("FAIL rst_req got %0b want 0", bus.rst_req);
        else n_pass++;
        rst_n = 1'b1;
        since = 0;
    endtask

    task automatic test_lock();
        toggle(10);
        wait_cyc(4);
        n_chk++;
        if (bus.period_meas !== 32'd0)
            $display("FAIL lock_init_pm got %0d want 0", bus.period_meas);
        else n_pass++;
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b0)
            $display("FAIL lock_early got %0b want 0", bus.locked);
        else n_pass++;
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b1)
            $display("FAIL lock_locked got %0b want 1", bus.locked);
        else n_pass++;
        n_chk++;
        if (bus.period_meas !== 32'd100)
            $display("FAIL lock_pm got %0d want 100", bus.period_meas);
        else n_pass++;
        n_chk++;
        if (bus.fault !== 1'b0)
            $display("FAIL lock_fault got %0b want 0", bus.fault);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int hi;
        toggle(95);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b1 || bus.period_meas !== 32'd95)
            $display("FAIL bnd_95 got locked=%0b pm=%0d want 1/95",
                     bus.locked, bus.period_meas);
        else n_pass++;
        toggle(105);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b1 || bus.period_meas !== 32'd105)
            $display("FAIL bnd_105 got locked=%0b pm=%0d want 1/105",
                     bus.locked, bus.period_meas);
        else n_pass++;
        toggle(95);
        toggle(105);
        wait_cyc(108 - since);
        n_chk++;
        if (bus.fault !== 1'b0 || bus.locked !== 1'b1)
            $display("FAIL bnd_tmo_pre got fault=%0b locked=%0b want 0/1",
                     bus.fault, bus.locked);
        else n_pass++;
        wait_cyc(1);
        n_chk++;
        if (bus.fault !== 1'b1)
            $display("FAIL late_fault got %0b want 1", bus.fault);
        else n_pass++;
        n_chk++;
        if (bus.fault_code !== 2'b10)
            $display("FAIL late_code got %0b want 10", bus.fault_code);
        else n_pass++;
        n_chk++;
        if (bus.locked !== 1'b0)
            $display("FAIL late_locked got %0b want 0", bus.locked);
        else n_pass++;
        n_chk++;
        if (bus.err_cnt !== 16'd1)
            $display("FAIL late_err got %0d want 1", bus.err_cnt);
        else n_pass++;
        n_chk++;
        if (bus.period_meas !== 32'd105)
            $display("FAIL late_pm got %0d want 105", bus.period_meas);
        else n_pass++;
        hi = (bus.rst_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 16; i++) begin
            wait_cyc(1);
            if (bus.rst_req === 1'b1) hi++;
        end
`ifdef HBMON_RST_REQ_EN
        n_chk++;
        if (hi != 16)
            $display("FAIL rstreq_width got %0d want 16", hi);
        else n_pass++;
        n_chk++;
        if (bus.rst_req !== 1'b0)
            $display("FAIL rstreq_end got %0b want 0", bus.rst_req);
        else n_pass++;
`else
        n_chk++;
        if (hi != 0)
            $display("FAIL rstreq_tied got %0d want 0", hi);
        else n_pass++;
`endif
    endtask

    task automatic test_clear();
        pulse_clr();
        n_chk++;
        if (bus.fault !== 1'b0 || bus.fault_code !== 2'b00)
            $display("FAIL clr_fault got %0b/%0b want 0/00",
                     bus.fault, bus.fault_code);
        else n_pass++;
        n_chk++;
        if (bus.err_cnt !== 16'd1)
            $display("FAIL clr_err got %0d want 1", bus.err_cnt);
        else n_pass++;
        toggle(10);
        toggle(100);
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b1)
            $display("FAIL clr_relock got %0b want 1", bus.locked);
        else n_pass++;
        pulse_clr();
        n_chk++;
        if (bus.locked !== 1'b1 || bus.fault !== 1'b0)
            $display("FAIL clr_ignored got locked=%0b fault=%0b want 1/0",
                     bus.locked, bus.fault);
        else n_pass++;
    endtask

    task automatic test_early();
        toggle(90);
        wait_cyc(4);
        n_chk++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b01)
            $display("FAIL early_fault got %0b/%0b want 1/01",
                     bus.fault, bus.fault_code);
        else n_pass++;
        n_chk++;
        if (bus.period_meas !== 32'd90)
            $display("FAIL early_pm got %0d want 90", bus.period_meas);
        else n_pass++;
        n_chk++;
        if (bus.err_cnt !== 16'd2)
            $display("FAIL early_err got %0d want 2", bus.err_cnt);
        else n_pass++;
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.fault !== 1'b1 || bus.period_meas !== 32'd90)
            $display("FAIL sticky got fault=%0b pm=%0d want 1/90",
                     bus.fault, bus.period_meas);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_clr();
        toggle(10);
        toggle(100);
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b1)
            $display("FAIL mid_prelock got %0b want 1", bus.locked);
        else n_pass++;
        wait_cyc(10);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.locked !== 1'b0 || bus.fault !== 1'b0 ||
            bus.fault_code !== 2'b00 || bus.rst_req !== 1'b0)
            $display("FAIL mid_rst_flags got l=%0b f=%0b c=%0b r=%0b want 0",
                     bus.locked, bus.fault, bus.fault_code, bus.rst_req);
        else n_pass++;
        n_chk++;
        if (bus.period_meas !== 32'd0 || bus.err_cnt !== 16'd0)
            $display("FAIL mid_rst_cnt got pm=%0d err=%0d want 0/0",
                     bus.period_meas, bus.err_cnt);
        else n_pass++;
        bus.hb_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        since = 0;
        toggle(10);
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b0 || bus.period_meas !== 32'd100)
            $display("FAIL mid_acq got locked=%0b pm=%0d want 0/100",
                     bus.locked, bus.period_meas);
        else n_pass++;
        toggle(100);
        wait_cyc(4);
        n_chk++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd0)
            $display("FAIL mid_relock got locked=%0b err=%0d want 1/0",
                     bus.locked, bus.err_cnt);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_lock();
        test_boundary();
        test_clear();
        test_early();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
